// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared state encoding and default timing for the TRNG controller
package trng_pkg;

    localparam int WARMUP_CYCLES_DEF = 64;
    localparam int SAMPLE_DIV_DEF    = 8;
    localparam int REP_LIMIT_DEF     = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERROR  = 3'd4
    } trng_state_e;

endpackage

// File: rtl/trng_sync.sv
// rtl/trng_sync.sv - two-flop synchronizer for the raw ring-oscillator bit
module trng_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - ring-oscillator TRNG: warm-up, von Neumann debias, word assembly, repetition test
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF,
    parameter int SAMPLE_DIV    = SAMPLE_DIV_DEF,
    parameter int REP_LIMIT     = REP_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        ro_sample,
    output logic        ro_en,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        health_err
);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int RW = $clog2(REP_LIMIT + 1);

    trng_state_e   state_q, state_d;
    logic [WW-1:0] warm_q, warm_d;
    logic [DW-1:0] div_q, div_d;
    logic          pair_vld_q, pair_vld_d;
    logic          pair_bit_q, pair_bit_d;
    logic [31:0]   word_q, word_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          last_q, last_d;
    logic [RW-1:0] rep_next;
    logic          raw_bit;

    trng_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ro_sample),
        .q     (raw_bit)
    );

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        div_d      = div_q;
        pair_vld_d = pair_vld_q;
        pair_bit_d = pair_bit_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        rep_d      = rep_q;
        last_d     = last_q;
        rep_next   = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (warm_q == WW'(WARMUP_CYCLES - 1)) begin
                    state_d    = ST_SAMPLE;
                    div_d      = '0;
                    pair_vld_d = 1'b0;
                    pair_bit_d = 1'b0;
                    cnt_d      = '0;
                    word_d     = '0;
                    rep_d      = '0;
                    last_d     = 1'b0;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            ST_SAMPLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (div_q != DW'(SAMPLE_DIV - 1)) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d    = '0;
                    // rep_q == 0 marks "no previous sample yet"
                    rep_next = (rep_q != '0 && raw_bit == last_q) ? rep_q + RW'(1) : RW'(1);
                    rep_d    = rep_next;
                    last_d   = raw_bit;
                    if (!pair_vld_q) begin
                        pair_vld_d = 1'b1;
                        pair_bit_d = raw_bit;
                    end else begin
                        pair_vld_d = 1'b0;
                        pair_bit_d = 1'b0;
                        if (pair_bit_q != raw_bit) begin
                            word_d = {word_q[30:0], pair_bit_q};
                            cnt_d  = cnt_q + 6'd1;
                            if (cnt_q == 6'd31) state_d = ST_HOLD;
                        end
                    end
                    if (rep_next == RW'(REP_LIMIT)) state_d = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (word_ready) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            ST_ERROR: begin
                if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // abandoning a run drops any partial or pending word
        if (state_d == ST_IDLE || state_d == ST_ERROR) begin
            word_d     = '0;
            cnt_d      = '0;
            pair_vld_d = 1'b0;
            pair_bit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            warm_q     <= '0;
            div_q      <= '0;
            pair_vld_q <= 1'b0;
            pair_bit_q <= 1'b0;
            word_q     <= '0;
            cnt_q      <= '0;
            rep_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_q     <= warm_d;
            div_q      <= div_d;
            pair_vld_q <= pair_vld_d;
            pair_bit_q <= pair_bit_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            last_q     <= last_d;
        end
    end

    assign ro_en      = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE) || (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign word_valid = (state_q == ST_HOLD);
    assign word_data  = word_valid ? word_q : 32'd0;
    assign health_err = (state_q == ST_ERROR);

endmodule
